// File: rtl/iz_pkg.sv
// Shared definitions for the Izhikevich neuron core: frame marker, x64 fixed-point
// parameter defaults and the loader state encoding.
package iz_pkg;

    localparam int               SCALE         = 64;
    localparam logic [7:0]       SYNC_BYTE_DEF = 8'hA5;
    localparam logic signed [15:0] DEF_A_X64   = 16'sd1;
    localparam logic signed [15:0] DEF_B_X64   = 16'sd13;
    localparam logic signed [15:0] DEF_C_X64   = -16'sd4160;
    localparam logic signed [15:0] DEF_D_X64   = 16'sd512;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    // Raw two's-complement join of a little-endian byte pair, no saturation.
    function automatic logic signed [15:0] assemble(input logic [7:0] hi, input logic [7:0] lo);
        return signed'({hi, lo});
    endfunction

endpackage

// File: rtl/iz_byte_timeout.sv
// Inter-byte watchdog: counts consecutive idle cycles while run is high and raises
// expire on the cycle that would complete TIMEOUT idle cycles.
module iz_byte_timeout #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic kick,
    output logic expire
);

    logic [15:0] timer_q;
    logic [15:0] timer_d;

    // A byte arriving on the expiry cycle wins: kick suppresses expire.
    assign expire = run && !kick && (timer_q == TIMEOUT - 16'd1);

    always_comb begin
        timer_d = timer_q + 16'd1;
        if (!run || kick || expire) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/iz_param_loader.sv
// Loads Izhikevich a/b/c/d from a checksummed byte frame into shadow registers and
// commits them atomically to the neuron core only when the checksum matches.
module iz_param_loader
    import iz_pkg::*;
#(
    parameter logic [7:0]         SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter logic [15:0]        TIMEOUT        = 16'd1000,
    parameter logic signed [15:0] DEF_A          = DEF_A_X64,
    parameter logic signed [15:0] DEF_B          = DEF_B_X64,
    parameter logic signed [15:0] DEF_C          = DEF_C_X64,
    parameter logic signed [15:0] DEF_D          = DEF_D_X64,
    parameter logic               READY_AT_RESET = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         data_in,
    input  logic               data_valid,
    output logic signed [15:0] param_a,
    output logic signed [15:0] param_b,
    output logic signed [15:0] param_c,
    output logic signed [15:0] param_d,
    output logic               params_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_error
);

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          shadow_q [8];
    logic [7:0]          shadow_d [8];
    logic signed [15:0]  param_a_q, param_a_d, param_b_q, param_b_d;
    logic signed [15:0]  param_c_q, param_c_d, param_d_q, param_d_d;
    logic                ready_q, ready_d, set_valid_q, set_valid_d;
    logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                expire, commit, abort;

    iz_byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .run    (busy_q),
        .kick   (data_valid),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        shadow_d    = shadow_q;
        param_a_d   = param_a_q;
        param_b_d   = param_b_q;
        param_c_d   = param_c_q;
        param_d_d   = param_d_q;
        ready_d     = ready_q;
        set_valid_d = set_valid_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        commit      = 1'b0;
        abort       = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_valid && data_in == SYNC_BYTE) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                    csum_d  = '0;
                    ready_d = 1'b0;
                end
            end
            PAYLOAD: begin
                if (data_valid) begin
                    shadow_d[idx_q] = data_in;
                    csum_d          = csum_q ^ data_in;
                    idx_d           = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = CHECK;
                    end
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            CHECK: begin
                if (data_valid) begin
                    commit = (data_in == csum_q);
                    abort  = (data_in != csum_q);
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs only ever move here, so the core never sees a half-loaded set.
        if (commit) begin
            param_a_d   = assemble(shadow_q[1], shadow_q[0]);
            param_b_d   = assemble(shadow_q[3], shadow_q[2]);
            param_c_d   = assemble(shadow_q[5], shadow_q[4]);
            param_d_d   = assemble(shadow_q[7], shadow_q[6]);
            set_valid_d = 1'b1;
            ready_d     = 1'b1;
            done_d      = 1'b1;
            state_d     = IDLE;
        end
        if (abort) begin
            ready_d = set_valid_q;
            error_d = 1'b1;
            state_d = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            csum_q      <= '0;
            param_a_q   <= DEF_A;
            param_b_q   <= DEF_B;
            param_c_q   <= DEF_C;
            param_d_q   <= DEF_D;
            ready_q     <= READY_AT_RESET;
            set_valid_q <= READY_AT_RESET;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            param_a_q   <= param_a_d;
            param_b_q   <= param_b_d;
            param_c_q   <= param_c_d;
            param_d_q   <= param_d_d;
            ready_q     <= ready_d;
            set_valid_q <= set_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Shadow bytes are pure data; they are always rewritten before being committed.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    assign param_a      = param_a_q;
    assign param_b      = param_b_q;
    assign param_c      = param_c_q;
    assign param_d      = param_d_q;
    assign params_ready = ready_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign frame_error  = error_q;

endmodule

// File: tb/tb_iz_param_loader.sv
// Bench for iz_param_loader: a frame-level reference model checked every cycle plus
// literal expectations after each directed scenario.
module tb_iz_param_loader;

    localparam logic [15:0] TMO = 16'd8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        data_in = 8'h00;
    logic              data_valid = 1'b0;
    logic signed [15:0] param_a, param_b, param_c, param_d;
    logic              params_ready, busy, frame_done, frame_error;

    int errors = 0;
    int checks = 0;

    iz_param_loader #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .param_a      (param_a),
        .param_b      (param_b),
        .param_c      (param_c),
        .param_d      (param_d),
        .params_ready (params_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    // Frame-level model: collect the bytes after a sync, judge the frame when the
    // ninth byte arrives, or give up after TMO consecutive silent cycles.
    int          m_a, m_b, m_c, m_d;
    bit          m_ready, m_set, m_busy, m_done, m_err, m_in;
    int          m_n, m_idle;
    logic [7:0]  m_buf [8];
    logic [7:0]  x;
    bit          started = 0;

    always @(posedge clk) begin
        m_done = 0;
        m_err  = 0;
        if (reset) begin
            m_a = 1; m_b = 13; m_c = -4160; m_d = 512;
            m_ready = 0; m_set = 0; m_in = 0; m_n = 0; m_idle = 0;
        end else if (!m_in) begin
            if (data_valid && data_in == 8'hA5) begin
                m_in = 1; m_n = 0; m_idle = 0; m_ready = 0;
            end
        end else if (data_valid) begin
            m_idle = 0;
            if (m_n < 8) begin
                m_buf[m_n] = data_in;
                m_n++;
            end else begin
                x = 8'h00;
                for (int i = 0; i < 8; i++) x ^= m_buf[i];
                if (x == data_in) begin
                    m_a = int'($signed({m_buf[1], m_buf[0]}));
                    m_b = int'($signed({m_buf[3], m_buf[2]}));
                    m_c = int'($signed({m_buf[5], m_buf[4]}));
                    m_d = int'($signed({m_buf[7], m_buf[6]}));
                    m_set = 1; m_ready = 1; m_done = 1;
                end else begin
                    m_ready = m_set; m_err = 1;
                end
                m_in = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == int'(TMO)) begin
                m_ready = m_set; m_err = 1; m_in = 0;
            end
        end
        m_busy  = m_in;
        started = 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model param_a", int'(param_a), m_a);
            chk("model param_b", int'(param_b), m_b);
            chk("model param_c", int'(param_c), m_c);
            chk("model param_d", int'(param_d), m_d);
            chk("model params_ready", int'(params_ready), int'(m_ready));
            chk("model busy", int'(busy), int'(m_busy));
            chk("model frame_done", int'(frame_done), int'(m_done));
            chk("model frame_error", int'(frame_error), int'(m_err));
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        data_in    = b;
        data_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] f [10]);
        for (int i = 0; i < 10; i++) send(f[i]);
    endtask

    task automatic pin_params(input string tag, input int a, input int b, input int c, input int d);
        #1;
        chk({tag, " a"}, int'(param_a), a);
        chk({tag, " b"}, int'(param_b), b);
        chk({tag, " c"}, int'(param_c), c);
        chk({tag, " d"}, int'(param_d), d);
    endtask

    logic [7:0] good [10] = '{8'hA5, 8'h02, 8'h00, 8'h0D, 8'h00, 8'hC0, 8'hEF, 8'h00, 8'h02, 8'h22};
    logic [7:0] bad  [10] = '{8'hA5, 8'h02, 8'h00, 8'h0D, 8'h00, 8'hC0, 8'hEF, 8'h00, 8'h02, 8'h21};
    logic [7:0] syncy[10] = '{8'hA5, 8'hA5, 8'h00, 8'h14, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h01, 8'h40};

    initial begin
        // Reset defaults
        idle(3);
        reset = 1'b0;
        pin_params("reset", 1, 13, -4160, 512);
        chk("reset ready", int'(params_ready), 0);
        chk("reset busy", int'(busy), 0);
        idle(2);

        // Good frame commits the cycle after CHK
        send_frame(good);
        idle(1);
        pin_params("commit", 2, 13, -4160, 512);
        chk("commit done", int'(frame_done), 1);
        chk("commit ready", int'(params_ready), 1);
        idle(2);

        // Bad checksum keeps the committed set and restores ready
        send(8'hA5);
        idle(1);
        #1 chk("sync drops ready", int'(params_ready), 0);
        for (int i = 1; i < 10; i++) send(bad[i]);
        idle(1);
        pin_params("badchk", 2, 13, -4160, 512);
        chk("badchk error", int'(frame_error), 1);
        chk("badchk ready", int'(params_ready), 1);
        idle(2);

        // Timeout: silent for exactly TMO cycles after three payload bytes
        send(8'hA5); send(8'h11); send(8'h22); send(8'h33);
        idle(int'(TMO));
        #1 chk("tmo not yet error", int'(frame_error), 0);
        chk("tmo still busy", int'(busy), 1);
        idle(1);
        #1 chk("tmo error", int'(frame_error), 1);
        chk("tmo busy", int'(busy), 0);
        pin_params("tmo", 2, 13, -4160, 512);
        idle(2);

        // Junk before sync, then 0xA5 appearing inside the payload
        send(8'h00); send(8'hFF);
        send_frame(syncy);
        idle(1);
        pin_params("sync payload", 165, 20, -4096, 256);
        chk("sync payload done", int'(frame_done), 1);
        idle(2);

        // Reset mid-payload, then a clean frame
        send(8'hA5); send(8'h01); send(8'h02);
        @(negedge clk);
        data_valid = 1'b0;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        pin_params("midreset", 1, 13, -4160, 512);
        chk("midreset busy", int'(busy), 0);
        chk("midreset ready", int'(params_ready), 0);
        idle(1);
        send_frame(good);
        idle(1);
        pin_params("after reset", 2, 13, -4160, 512);
        chk("after reset ready", int'(params_ready), 1);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
